chime_slot_allocator: RTL and testbench
=======================================

// Module: chime_slot_allocator
// PURPOSE
//  Voice scheduler between the melody sequencer and the tone-generator slots.
//  Accepts note-on/note-off requests on a valid/ready port and assigns each
//  note-on to a free slot, or steals the oldest slot when none is free.
//  Drives the shared slot write bus: divider value, gate and a one-hot
//  write-enable pulse.
//  Tracks per-slot age in ms so decayed slots are reused.
// PARAMETERS
//  C_SLOTS    4     number of tone-generator slots, 2..8
//  C_DIV_W    7     width of the note divider field
//  C_HOLD_MS  1500  ms after note-on before a slot counts as free (envelope decayed)
// PORTS
//  CK_i             in   1        system clock
//  XARST_i          in   1        reset, asynchronous, active-low
//  EE_1KHZ_i        in   1        1 ms timing pulse, one CK wide
//  REQ_VALID_i      in   1        request valid
//  REQ_READY_o      out  1        request accepted when VALID&READY
//  REQ_NOTE_i       in   1        1 = note-on, 0 = note-off
//  REQ_DIVs_i       in   C_DIV_W  note divider (pitch key)
//  SLOT_divs_o      out  C_DIV_W  divider on the slot write bus
//  SLOT_note_o      out  1        gate on the slot write bus
//  SLOTs_WT_REQ_o   out  C_SLOTS  one-hot slot write enable, 1-CK pulse
//  ACTIVE_o         out  C_SLOTS  slot is within its hold time
//  STEAL_o          out  1        1-CK pulse when a note-on stole a busy slot
// BEHAVIOUR
//  Reset values:
//   - REQ_READY_o=1; SLOT_divs_o=0; SLOT_note_o=0; SLOTs_WT_REQ_o=0; ACTIVE_o=0; STEAL_o=0.
//   - All ages=0, gates=0, stored divs=0, FSM=IDLE.
//  FSM has three states: IDLE -> SCAN -> WRITE -> IDLE.
//   - IDLE: READY=1. VALID&READY latches NOTE/DIVs and moves to SCAN.
//   - SCAN: READY=0; picks the target slot (rules below); WRITE follows next CK.
//   - WRITE: drives the bus plus one WT_REQ bit for exactly 1 CK, or no pulse if
//     the request is dropped; returns to IDLE.
//  Latency and throughput:
//   - Accept at cycle N; WT_REQ/STEAL pulse at N+2; next accept at N+3 at the earliest.
//   - SLOT_divs_o/SLOT_note_o hold their last written value between writes.
//  Note-on target selection:
//   - The lowest-index slot with ACTIVE=0 is chosen.
//   - If every slot is ACTIVE, the slot with the largest age is chosen (ties go
//     to the lowest index), and STEAL_o pulses together with WT_REQ.
//   - Bus gets note=1, div=REQ_DIVs. The slot's age goes to 0, gate=1, ACTIVE=1,
//     and the stored div takes REQ_DIVs.
//  Note-off target selection:
//   - The lowest-index slot with gate=1 and stored div == REQ_DIVs is chosen.
//   - Bus gets note=0, div=stored div. The slot's gate goes to 0; ACTIVE and age
//     continue unchanged (release tail).
//   - If no slot matches, the request is dropped: no WT_REQ, no STEAL, state unchanged.
//  Age counters:
//   - Width log2(C_HOLD_MS+1). Each counter increments on EE_1KHZ_i while its
//     slot is ACTIVE.
//   - When age reaches C_HOLD_MS: ACTIVE is cleared and gate is cleared in the
//     same CK, with no bus write. The age then holds at C_HOLD_MS.
//  Boundary cases:
//   - EE_1KHZ_i in the same CK as a note-on write to slot k: slot k age=0; other
//     slots increment normally.
//   - Expiry in the same CK as SCAN: SCAN uses pre-update ACTIVE. A slot that
//     expires then is still a legal target (treated as steal only if all were
//     ACTIVE at SCAN).
//   - VALID held with no READY: inputs are ignored until IDLE; the requester
//     holds data stable.
//   - Reset asserted mid-SCAN/WRITE: every output returns to its reset value
//     at once; the pending request is lost.
// TESTING
//  1. Reset, then on(div=40) -> WT_REQ=0001 at N+2, SLOT_divs_o=40, note=1, ACTIVE=0001, STEAL=0.
//  2. On 10,20,30,40 back-to-back (one ms apart) -> WT_REQ 0001,0010,0100,1000;
//     then on 50 -> WT_REQ=0001, STEAL=1.
//  3. On(20) then off(20) -> second write WT_REQ=0001, note=0, div=20; ACTIVE
//     stays 1; off(33) -> no WT_REQ, READY back to 1 after 3 CK.
//  4. On(25) then 1500 EE_1KHZ pulses -> ACTIVE clears on the 1500th with no
//     write; the next on reuses slot 0, STEAL=0.
//  5. VALID high continuously -> READY pattern 1,0,0,1; accept count = WT_REQ count.
//  6. XARST_i low during SCAN -> no WT_REQ pulse; all outputs at reset values; READY=1 after release.

Source files
------------

// File: rtl/chime_slot_allocator.sv
// Voice scheduler: maps note-on/note-off requests onto tone-generator slots,
// stealing the oldest slot when all are sounding, and ages slots in ms ticks.
module chime_slot_allocator #(
    parameter int C_SLOTS   = 4,
    parameter int C_DIV_W   = 7,
    parameter int C_HOLD_MS = 1500
) (
    input  logic                 CK_i,
    input  logic                 XARST_i,
    input  logic                 EE_1KHZ_i,
    input  logic                 REQ_VALID_i,
    output logic                 REQ_READY_o,
    input  logic                 REQ_NOTE_i,
    input  logic [C_DIV_W-1:0]   REQ_DIVs_i,
    output logic [C_DIV_W-1:0]   SLOT_divs_o,
    output logic                 SLOT_note_o,
    output logic [C_SLOTS-1:0]   SLOTs_WT_REQ_o,
    output logic [C_SLOTS-1:0]   ACTIVE_o,
    output logic                 STEAL_o
);

    localparam int C_AGE_W = $clog2(C_HOLD_MS + 1);
    localparam int C_IDX_W = (C_SLOTS > 1) ? $clog2(C_SLOTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t               state_r;
    logic                 req_note_r;
    logic [C_DIV_W-1:0]   req_div_r;
    logic                 ready_r;
    logic [C_DIV_W-1:0]   slot_divs_r;
    logic                 slot_note_r;
    logic [C_SLOTS-1:0]   wt_req_r;
    logic                 steal_r;
    logic [C_SLOTS-1:0]   active_r;
    logic [C_SLOTS-1:0]   gate_r;
    logic [C_AGE_W-1:0]   age_r  [C_SLOTS];
    logic [C_DIV_W-1:0]   sdiv_r [C_SLOTS];

    logic                 free_found_s;
    logic [C_IDX_W-1:0]   free_idx_s;
    logic [C_IDX_W-1:0]   old_idx_s;
    logic [C_AGE_W-1:0]   old_age_s;
    logic                 match_found_s;
    logic [C_IDX_W-1:0]   match_idx_s;
    logic                 hit_s;
    logic                 steal_s;
    logic [C_IDX_W-1:0]   tgt_s;
    logic [C_SLOTS-1:0]   tgt_onehot_s;

    // Target selection for the latched request, from pre-update slot state.
    always_comb begin
        free_found_s  = 1'b0;
        free_idx_s    = {C_IDX_W{1'b0}};
        match_found_s = 1'b0;
        match_idx_s   = {C_IDX_W{1'b0}};
        old_idx_s     = {C_IDX_W{1'b0}};
        old_age_s     = age_r[0];
        // Descending scans let the lowest matching index win.
        for (int i = C_SLOTS - 1; i >= 0; i--) begin
            if (!active_r[i]) begin
                free_found_s = 1'b1;
                free_idx_s   = C_IDX_W'(i);
            end else begin
                free_found_s = free_found_s;
            end
            if (gate_r[i] && (sdiv_r[i] == req_div_r)) begin
                match_found_s = 1'b1;
                match_idx_s   = C_IDX_W'(i);
            end else begin
                match_found_s = match_found_s;
            end
        end
        // Strict compare keeps the lowest index on equal ages.
        for (int i = 1; i < C_SLOTS; i++) begin
            if (age_r[i] > old_age_s) begin
                old_age_s = age_r[i];
                old_idx_s = C_IDX_W'(i);
            end else begin
                old_age_s = old_age_s;
            end
        end
        if (req_note_r) begin
            hit_s   = 1'b1;
            steal_s = !free_found_s;
            tgt_s   = free_found_s ? free_idx_s : old_idx_s;
        end else begin
            hit_s   = match_found_s;
            steal_s = 1'b0;
            tgt_s   = match_idx_s;
        end
        if (hit_s) begin
            tgt_onehot_s = {{(C_SLOTS-1){1'b0}}, 1'b1} << tgt_s;
        end else begin
            tgt_onehot_s = {C_SLOTS{1'b0}};
        end
    end

    // Request FSM, slot write bus and per-slot age/gate/active state.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            state_r     <= ST_IDLE;
            req_note_r  <= 1'b0;
            req_div_r   <= {C_DIV_W{1'b0}};
            ready_r     <= 1'b1;
            slot_divs_r <= {C_DIV_W{1'b0}};
            slot_note_r <= 1'b0;
            wt_req_r    <= {C_SLOTS{1'b0}};
            steal_r     <= 1'b0;
            active_r    <= {C_SLOTS{1'b0}};
            gate_r      <= {C_SLOTS{1'b0}};
            for (int i = 0; i < C_SLOTS; i++) begin
                age_r[i]  <= {C_AGE_W{1'b0}};
                sdiv_r[i] <= {C_DIV_W{1'b0}};
            end
        end else begin
            // Ageing; reaching the hold time silently frees the slot.
            for (int i = 0; i < C_SLOTS; i++) begin
                if (active_r[i] && EE_1KHZ_i) begin
                    if (age_r[i] == C_AGE_W'(C_HOLD_MS - 1)) begin
                        age_r[i]    <= C_AGE_W'(C_HOLD_MS);
                        active_r[i] <= 1'b0;
                        gate_r[i]   <= 1'b0;
                    end else begin
                        age_r[i] <= age_r[i] + C_AGE_W'(1);
                    end
                end else begin
                    age_r[i] <= age_r[i];
                end
            end

            case (state_r)
                ST_IDLE: begin
                    wt_req_r <= {C_SLOTS{1'b0}};
                    steal_r  <= 1'b0;
                    if (REQ_VALID_i && ready_r) begin
                        req_note_r <= REQ_NOTE_i;
                        req_div_r  <= REQ_DIVs_i;
                        ready_r    <= 1'b0;
                        state_r    <= ST_SCAN;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    // Slot updates placed after ageing so a write overrides a same-CK tick.
                    wt_req_r <= tgt_onehot_s;
                    steal_r  <= steal_s;
                    state_r  <= ST_WRITE;
                    if (hit_s) begin
                        slot_note_r <= req_note_r;
                        if (req_note_r) begin
                            slot_divs_r     <= req_div_r;
                            age_r[tgt_s]    <= {C_AGE_W{1'b0}};
                            active_r[tgt_s] <= 1'b1;
                            gate_r[tgt_s]   <= 1'b1;
                            sdiv_r[tgt_s]   <= req_div_r;
                        end else begin
                            slot_divs_r   <= sdiv_r[tgt_s];
                            gate_r[tgt_s] <= 1'b0;
                        end
                    end else begin
                        slot_note_r <= slot_note_r;
                    end
                end
                ST_WRITE: begin
                    wt_req_r <= {C_SLOTS{1'b0}};
                    steal_r  <= 1'b0;
                    ready_r  <= 1'b1;
                    state_r  <= ST_IDLE;
                end
                default: begin
                    wt_req_r <= {C_SLOTS{1'b0}};
                    steal_r  <= 1'b0;
                    ready_r  <= 1'b1;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign REQ_READY_o    = ready_r;
    assign SLOT_divs_o    = slot_divs_r;
    assign SLOT_note_o    = slot_note_r;
    assign SLOTs_WT_REQ_o = wt_req_r;
    assign ACTIVE_o       = active_r;
    assign STEAL_o        = steal_r;

endmodule

// File: tb/tb_chime_slot_allocator.sv
// Self-checking bench for chime_slot_allocator: directed scenarios plus random
// traffic against a timestamp-based voice model.
module tb_chime_slot_allocator;

    localparam int S    = 4;
    localparam int W    = 7;
    localparam int HOLD = 1500;

    logic         ck = 1'b0;
    logic         xarst = 1'b0;
    logic         ee = 1'b0;
    logic         valid = 1'b0;
    logic         ready;
    logic         note_i = 1'b0;
    logic [W-1:0] div_i = '0;
    logic [W-1:0] slot_divs;
    logic         slot_note;
    logic [S-1:0] wt_req;
    logic [S-1:0] active;
    logic         steal;

    int tests_run = 0;
    int fails = 0;

    // Model: each slot remembers the ms count at its note-on; age is the difference.
    int ms_now;
    int on_ms [S];
    bit ever_on [S];
    bit gate_m [S];
    int sdiv_m [S];
    int bus_div_m;
    bit bus_note_m;

    chime_slot_allocator dut (
        .CK_i(ck), .XARST_i(xarst), .EE_1KHZ_i(ee),
        .REQ_VALID_i(valid), .REQ_READY_o(ready), .REQ_NOTE_i(note_i),
        .REQ_DIVs_i(div_i), .SLOT_divs_o(slot_divs), .SLOT_note_o(slot_note),
        .SLOTs_WT_REQ_o(wt_req), .ACTIVE_o(active), .STEAL_o(steal)
    );

    always #5 ck = ~ck;

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    function automatic bit m_active(input int k);
        return ever_on[k] && ((ms_now - on_ms[k]) < HOLD);
    endfunction

    function automatic logic [S-1:0] m_active_vec();
        logic [S-1:0] v;
        for (int k = 0; k < S; k++) v[k] = m_active(k);
        return v;
    endfunction

    function automatic void m_reset();
        ms_now = 0; bus_div_m = 0; bus_note_m = 1'b0;
        for (int k = 0; k < S; k++) begin
            on_ms[k] = 0; ever_on[k] = 1'b0; gate_m[k] = 1'b0; sdiv_m[k] = 0;
        end
    endfunction

    // Returns target slot (-1 when dropped) and whether it is a steal.
    function automatic int m_predict(input bit nt, input int dv, output bit st);
        int t;
        t = -1; st = 1'b0;
        if (nt) begin
            for (int k = 0; k < S && t < 0; k++) if (!m_active(k)) t = k;
            if (t < 0) begin
                st = 1'b1; t = 0;
                for (int k = 1; k < S; k++) if (on_ms[k] < on_ms[t]) t = k;
            end
        end else begin
            for (int k = 0; k < S && t < 0; k++)
                if (gate_m[k] && m_active(k) && sdiv_m[k] == dv) t = k;
        end
        return t;
    endfunction

    function automatic void m_apply(input bit nt, input int dv, input int t);
        if (t >= 0) begin
            bus_note_m = nt;
            if (nt) begin
                ever_on[t] = 1'b1; on_ms[t] = ms_now; gate_m[t] = 1'b1; sdiv_m[t] = dv;
                bus_div_m = dv;
            end else begin
                gate_m[t] = 1'b0;
                bus_div_m = sdiv_m[t];
            end
        end
    endfunction

    task automatic apply_reset();
        valid = 1'b0; ee = 1'b0; xarst = 1'b0;
        repeat (2) tick();
        #2 xarst = 1'b1;
        tick();
        m_reset();
    endtask

    task automatic pulse_ee(input int n);
        for (int i = 0; i < n; i++) begin
            ee = 1'b1; tick(); ee = 1'b0; tick();
            ms_now++;
        end
    endtask

    // One request transaction; samples the bus in the WRITE cycle.
    task automatic do_req(input bit nt, input int dv, input bit ee_scan,
                          output logic [S-1:0] wt, output logic st,
                          output logic [W-1:0] bdiv, output logic bnote,
                          output logic rdy_mid, output logic rdy_end);
        valid = 1'b1; note_i = nt; div_i = W'(dv);
        tick();
        valid = 1'b0;
        rdy_mid = ready;
        ee = ee_scan;
        tick();
        ee = 1'b0;
        if (ee_scan) ms_now++;
        wt = wt_req; st = steal; bdiv = slot_divs; bnote = slot_note;
        tick();
        rdy_end = ready;
    endtask

    task automatic test_reset();
        xarst = 1'b0; valid = 1'b0; ee = 1'b0;
        tick();
        tests_run++;
        if ({ready, slot_divs, slot_note, wt_req, active, steal} !== {1'b1, {W{1'b0}}, 1'b0, {S{1'b0}}, {S{1'b0}}, 1'b0}) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b div=%0d note=%b wt=%b act=%b st=%b, want 1 0 0 0000 0000 0",
                     ready, slot_divs, slot_note, wt_req, active, steal);
        end
        apply_reset();
    endtask

    task automatic test_first_note();
        logic [S-1:0] wt; logic st, bn, rm, re; logic [W-1:0] bd;
        apply_reset();
        do_req(1'b1, 40, 1'b0, wt, st, bd, bn, rm, re);
        tests_run++;
        if ({wt, st, bd, bn, rm} !== {4'b0001, 1'b0, 7'd40, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL first_note: got wt=%b st=%b div=%0d note=%b rdy_mid=%b, want 0001 0 40 1 0", wt, st, bd, bn, rm);
        end
        tests_run++;
        if (active !== 4'b0001 || re !== 1'b1 || wt_req !== 4'b0000) begin
            fails++;
            $display("FAIL first_note_after: got act=%b rdy=%b wt=%b, want 0001 1 0000", active, re, wt_req);
        end
    endtask

    task automatic test_fill_and_steal();
        logic [S-1:0] wt; logic st, bn, rm, re; logic [W-1:0] bd;
        logic [S-1:0] exp_wt;
        apply_reset();
        for (int k = 0; k < S; k++) begin
            do_req(1'b1, 10 * (k + 1), 1'b0, wt, st, bd, bn, rm, re);
            exp_wt = S'(1) << k;
            tests_run++;
            if (wt !== exp_wt || st !== 1'b0 || bd !== W'(10 * (k + 1))) begin
                fails++;
                $display("FAIL fill_slot%0d: got wt=%b st=%b div=%0d, want %b 0 %0d", k, wt, st, bd, exp_wt, 10 * (k + 1));
            end
            if (k < S - 1) pulse_ee(1);
        end
        do_req(1'b1, 50, 1'b0, wt, st, bd, bn, rm, re);
        tests_run++;
        if (wt !== 4'b0001 || st !== 1'b1 || bd !== 7'd50 || active !== 4'b1111) begin
            fails++;
            $display("FAIL steal_oldest: got wt=%b st=%b div=%0d act=%b, want 0001 1 50 1111", wt, st, bd, active);
        end
    endtask

    task automatic test_note_off();
        logic [S-1:0] wt; logic st, bn, rm, re; logic [W-1:0] bd;
        apply_reset();
        do_req(1'b1, 20, 1'b0, wt, st, bd, bn, rm, re);
        do_req(1'b0, 20, 1'b0, wt, st, bd, bn, rm, re);
        tests_run++;
        if (wt !== 4'b0001 || bn !== 1'b0 || bd !== 7'd20 || active !== 4'b0001) begin
            fails++;
            $display("FAIL note_off_match: got wt=%b note=%b div=%0d act=%b, want 0001 0 20 0001", wt, bn, bd, active);
        end
        do_req(1'b0, 33, 1'b0, wt, st, bd, bn, rm, re);
        tests_run++;
        if (wt !== 4'b0000 || st !== 1'b0 || re !== 1'b1 || bd !== 7'd20 || bn !== 1'b0) begin
            fails++;
            $display("FAIL note_off_drop: got wt=%b st=%b rdy=%b div=%0d note=%b, want 0000 0 1 20 0", wt, st, re, bd, bn);
        end
        // Released slot's div must no longer match a second note-off.
        do_req(1'b0, 20, 1'b0, wt, st, bd, bn, rm, re);
        tests_run++;
        if (wt !== 4'b0000) begin
            fails++;
            $display("FAIL note_off_twice: got wt=%b, want 0000", wt);
        end
    endtask

    task automatic test_expiry();
        logic [S-1:0] wt; logic st, bn, rm, re; logic [W-1:0] bd;
        apply_reset();
        do_req(1'b1, 25, 1'b0, wt, st, bd, bn, rm, re);
        pulse_ee(HOLD - 1);
        tests_run++;
        if (active !== 4'b0001) begin
            fails++;
            $display("FAIL expiry_before: got act=%b, want 0001 after %0d ms", active, HOLD - 1);
        end
        ee = 1'b1; tick(); ee = 1'b0; ms_now++;
        tests_run++;
        if (active !== 4'b0000 || wt_req !== 4'b0000) begin
            fails++;
            $display("FAIL expiry_edge: got act=%b wt=%b, want 0000 0000", active, wt_req);
        end
        tick();
        do_req(1'b1, 26, 1'b0, wt, st, bd, bn, rm, re);
        tests_run++;
        if (wt !== 4'b0001 || st !== 1'b0) begin
            fails++;
            $display("FAIL expiry_reuse: got wt=%b st=%b, want 0001 0", wt, st);
        end
    endtask

    task automatic test_ms_boundaries();
        logic [S-1:0] wt; logic st, bn, rm, re; logic [W-1:0] bd;
        apply_reset();
        do_req(1'b1, 10, 1'b0, wt, st, bd, bn, rm, re);
        do_req(1'b1, 20, 1'b1, wt, st, bd, bn, rm, re);
        pulse_ee(HOLD - 2);
        tests_run++;
        if (active !== 4'b0011) begin
            fails++;
            $display("FAIL tick_on_write_a: got act=%b, want 0011", active);
        end
        pulse_ee(1);
        tests_run++;
        if (active !== 4'b0010) begin
            fails++;
            $display("FAIL tick_on_write_b: got act=%b, want 0010", active);
        end
        pulse_ee(1);
        tests_run++;
        if (active !== 4'b0000) begin
            fails++;
            $display("FAIL tick_on_write_c: got act=%b, want 0000", active);
        end
        // All four slots expire on the very CK the note-on is scanned.
        apply_reset();
        for (int k = 0; k < S; k++) do_req(1'b1, k + 1, 1'b0, wt, st, bd, bn, rm, re);
        pulse_ee(HOLD - 1);
        do_req(1'b1, 9, 1'b1, wt, st, bd, bn, rm, re);
        tests_run++;
        if (wt !== 4'b0001 || st !== 1'b1 || active !== 4'b0001) begin
            fails++;
            $display("FAIL expire_in_scan: got wt=%b st=%b act=%b, want 0001 1 0001", wt, st, active);
        end
    endtask

    task automatic test_back_to_back();
        int acc, wts;
        logic [11:0] rdy_seq;
        apply_reset();
        acc = 0; wts = 0;
        valid = 1'b1; note_i = 1'b1; div_i = 7'd60;
        for (int c = 0; c < 12; c++) begin
            rdy_seq[11 - c] = ready;
            if (ready) acc++;
            tick();
            if (wt_req !== 4'b0000) wts++;
        end
        valid = 1'b0;
        tick();
        tests_run++;
        if (rdy_seq !== 12'b100100100100) begin
            fails++;
            $display("FAIL b2b_ready_pattern: got %b, want 100100100100", rdy_seq);
        end
        tests_run++;
        if (acc != 4 || wts != 4 || active !== 4'b1111) begin
            fails++;
            $display("FAIL b2b_counts: got accepts=%0d writes=%0d act=%b, want 4 4 1111", acc, wts, active);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [S-1:0] wt; logic st, bn, rm, re; logic [W-1:0] bd;
        int seen;
        apply_reset();
        do_req(1'b1, 77, 1'b0, wt, st, bd, bn, rm, re);
        valid = 1'b1; note_i = 1'b1; div_i = 7'd55;
        tick();
        valid = 1'b0;
        #2 xarst = 1'b0;
        #1;
        tests_run++;
        if ({ready, slot_divs, slot_note, wt_req, active, steal} !== {1'b1, {W{1'b0}}, 1'b0, {S{1'b0}}, {S{1'b0}}, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_scan: got rdy=%b div=%0d note=%b wt=%b act=%b st=%b, want 1 0 0 0000 0000 0",
                     ready, slot_divs, slot_note, wt_req, active, steal);
        end
        tick();
        #2 xarst = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (wt_req !== 4'b0000 || ready !== 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            fails++;
            $display("FAIL reset_release: got %0d cycles with a write or ready=0, want 0", seen);
        end
        m_reset();
    endtask

    task automatic test_random();
        logic [S-1:0] wt, exp_wt, exp_act; logic st, bn, rm, re; logic [W-1:0] bd;
        bit exp_st, nt, es;
        int t, dv;
        apply_reset();
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                pulse_ee($urandom_range(0, 500));
                exp_act = m_active_vec();
                tests_run++;
                if (active !== exp_act) begin
                    fails++;
                    $display("FAIL rand_age[%0d]: got act=%b, want %b", it, active, exp_act);
                end
            end else begin
                nt = ($urandom_range(0, 2) != 0);
                dv = $urandom_range(5, 9);
                es = ($urandom_range(0, 4) == 0);
                t = m_predict(nt, dv, exp_st);
                exp_wt = (t >= 0) ? (S'(1) << t) : '0;
                do_req(nt, dv, es, wt, st, bd, bn, rm, re);
                m_apply(nt, dv, t);
                exp_act = m_active_vec();
                tests_run++;
                if (wt !== exp_wt || st !== exp_st || bd !== W'(bus_div_m) || bn !== bus_note_m ||
                    active !== exp_act || rm !== 1'b0 || re !== 1'b1) begin
                    fails++;
                    $display("FAIL rand_req[%0d] on=%b div=%0d: got wt=%b st=%b bus=%0d/%b act=%b rdy=%b%b, want %b %b %0d/%b %b 01",
                             it, nt, dv, wt, st, bd, bn, active, rm, re, exp_wt, exp_st, bus_div_m, bus_note_m, exp_act);
                end
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_first_note();
        test_fill_and_steal();
        test_note_off();
        test_expiry();
        test_ms_boundaries();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
